// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset PC, fetch FSM encodings and the fetch-buffer entry type.
package ifu_fetch_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned INST_WIDTH = 32;

  localparam logic [ADDR_WIDTH-1:0] FETCH_RESET_PC = 32'h8000_0000;

  // Fetch FSM encodings kept as plain constants for legacy tool flows.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_DROP = 2'd1;
  localparam fetch_state_t S_WAIT = 2'd2;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(3);
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: imem request/response, redirect from execute, and decode handshake.
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  logic                  fetch_req_valid;
  logic                  fetch_req_ready;
  logic [ADDR_WIDTH-1:0] fetch_req_addr;
  logic                  fetch_rsp_valid;
  logic [INST_WIDTH-1:0] fetch_rsp_inst;
  logic                  fetch_redir_en;
  logic [ADDR_WIDTH-1:0] fetch_redir_pc;
  logic                  fetch_valid;
  logic                  fetch_ready;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [INST_WIDTH-1:0] fetch_inst;
  logic [6:0]            fetch_opcode;

  // Fetch unit side.
  modport master (
    output fetch_req_valid, fetch_req_addr,
    input  fetch_req_ready,
    input  fetch_rsp_valid, fetch_rsp_inst,
    input  fetch_redir_en, fetch_redir_pc,
    output fetch_valid, fetch_pc, fetch_inst, fetch_opcode,
    input  fetch_ready
  );

  // Environment side: imem, execute and decode.
  modport slave (
    input  fetch_req_valid, fetch_req_addr,
    output fetch_req_ready,
    output fetch_rsp_valid, fetch_rsp_inst,
    output fetch_redir_en, fetch_redir_pc,
    input  fetch_valid, fetch_pc, fetch_inst, fetch_opcode,
    output fetch_ready
  );

endinterface

// File: rtl/ifu_fetch_fifo_sync.sv
// Synchronous FIFO with flush; push and pop may coincide at any fill level, including full.
module ifu_fetch_fifo_sync #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic [$clog2(Depth+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntFull);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the head slot this edge, so a push at full is still safe.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next-state for storage, pointers and occupancy; flush wins over everything.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata_i;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: PC ownership, single-outstanding imem requests, fetch buffer, redirects.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = FETCH_RESET_PC,
  parameter int unsigned           FIFO_DEPTH = 2
) (
  input logic         i_sys_clk,
  input logic         i_sys_rst_n,
  ifu_fetch_if.master fetch_io
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  active_q;

  logic                  req_valid;
  logic                  req_hs;
  logic                  push, pop;
  fetch_entry_t          push_entry, head_entry;
  logic [CntW-1:0]       fifo_count;
  logic                  fifo_full, fifo_empty;

  // active_q keeps the request low while reset is held and until the first edge after release.
  assign req_valid = active_q && (state_q == S_REQ) && (fifo_count < CntFull);
  assign req_hs    = req_valid && fetch_io.fetch_req_ready;

  assign fetch_io.fetch_req_valid = req_valid;
  assign fetch_io.fetch_req_addr  = pc_q;

  // A response that coincides with a redirect is stale and never enters the buffer.
  assign push       = fetch_io.fetch_rsp_valid && (state_q == S_WAIT) &&
                      !fetch_io.fetch_redir_en && (!fifo_full || pop);
  assign pop        = !fifo_empty && fetch_io.fetch_ready;
  assign push_entry = '{pc: req_pc_q, inst: fetch_io.fetch_rsp_inst};

  assign fetch_io.fetch_valid  = !fifo_empty;
  assign fetch_io.fetch_pc     = fifo_empty ? '0 : head_entry.pc;
  assign fetch_io.fetch_inst   = fifo_empty ? '0 : head_entry.inst;
  assign fetch_io.fetch_opcode = fetch_io.fetch_inst[6:0];

  // Fetch FSM and PC update; a redirect overrides the normal flow and never bumps the PC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    if (fetch_io.fetch_redir_en) begin
      pc_d = align_word(fetch_io.fetch_redir_pc);
      case (state_q)
        S_REQ:          state_d = req_hs ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = fetch_io.fetch_rsp_valid ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (req_hs) begin
            state_d  = S_WAIT;
            pc_d     = pc_q + ADDR_WIDTH'(4);
            req_pc_d = pc_q;
          end
        end
        S_WAIT, S_DROP: begin
          if (fetch_io.fetch_rsp_valid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // FSM, PC and request-address registers.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      active_q <= 1'b1;
    end
  end

  ifu_fetch_fifo_sync #(
    .Width($bits(fetch_entry_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (i_sys_clk),
    .rst_ni  (i_sys_rst_n),
    .flush_i (fetch_io.fetch_redir_en),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head_entry),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed request/redirect scenarios against a small imem model.
module tb_ifu_fetch;

  logic clk;
  logic rst_n;

  ifu_fetch_if bus ();

  ifu_fetch #(
    .RESET_PC   (32'h8000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .i_sys_clk   (clk),
    .i_sys_rst_n (rst_n),
    .fetch_io    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] exp_pc_q [$];   // expected decode-side outputs, in order
  logic [31:0] exp_req_q [$];  // expected imem request addresses, in order

  int          budget   = 0;   // imem accepts this many more requests
  int          lat      = 1;   // response latency in cycles after accept
  int          rsp_cnt  = 0;
  int          hs_count = 0;
  logic [31:0] pend_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Imem model: response after lat cycles, request accept gated by budget.
  initial begin
    bus.fetch_req_ready = 1'b0;
    bus.fetch_rsp_valid = 1'b0;
    bus.fetch_rsp_inst  = '0;
    forever begin
      @(negedge clk);
      bus.fetch_rsp_valid = 1'b0;
      if (!rst_n) begin
        rsp_cnt = 0;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          bus.fetch_rsp_valid = 1'b1;
          bus.fetch_rsp_inst  = mem_word(pend_addr);
        end
      end
      #1 bus.fetch_req_ready = (budget > 0);
      #1;
      if (rst_n && bus.fetch_req_valid && bus.fetch_req_ready) begin
        budget--;
        hs_count++;
        pend_addr = bus.fetch_req_addr;
        rsp_cnt   = lat;
        if (exp_req_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL req_unexpected actual=%h required=none", bus.fetch_req_addr);
        end else begin
          chk("req_addr", {32'h0, bus.fetch_req_addr}, {32'h0, exp_req_q.pop_front()});
        end
      end
    end
  end

  // Monitor: checks each accepted output against the scoreboard and request stability.
  initial begin
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [6:0]  e_op;
    prev_hold = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          chk("req_hold", {31'h0, bus.fetch_req_valid, bus.fetch_req_addr},
              {31'h0, 1'b1, prev_addr});
        end
        prev_hold = bus.fetch_req_valid && !bus.fetch_req_ready && !bus.fetch_redir_en;
        prev_addr = bus.fetch_req_addr;
        if (bus.fetch_valid && bus.fetch_ready && !bus.fetch_redir_en) begin
          if (exp_pc_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_unexpected actual=%h required=none", bus.fetch_pc);
          end else begin
            e_pc   = exp_pc_q.pop_front();
            e_inst = mem_word(e_pc);
            e_op   = e_inst[6:0];
            chk("out_pc_inst", {bus.fetch_pc, bus.fetch_inst}, {e_pc, e_inst});
            chk("out_opcode", {57'h0, bus.fetch_opcode}, {57'h0, e_op});
          end
        end
      end
    end
  end

  task automatic wait_hs(input string name, input int base);
    int k;
    k = 0;
    while (hs_count <= base && k < 50) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk({name, "_hs_seen"}, {63'h0, (hs_count > base)}, 64'h1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_pc_q.size() != 0 || exp_req_q.size() != 0 || rsp_cnt != 0) && k < 300) begin
      @(negedge clk);
      #3;
      k++;
    end
    chk({name, "_pending"}, 64'(exp_pc_q.size() + exp_req_q.size()), 64'h0);
    repeat (3) @(negedge clk);
    #3;
    chk({name, "_idle_valid"}, {63'h0, bus.fetch_valid}, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst_n              = 1'b0;
    bus.fetch_redir_en = 1'b0;
    bus.fetch_redir_pc = '0;
    bus.fetch_ready    = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req_valid", {63'h0, bus.fetch_req_valid}, 64'h0);
    chk("rst_valid", {63'h0, bus.fetch_valid}, 64'h0);
    chk("rst_pc_inst", {bus.fetch_pc, bus.fetch_inst}, 64'h0);
    chk("rst_opcode", {57'h0, bus.fetch_opcode}, 64'h0);

    // 1: straight-line fetch from the reset PC.
    exp_req_q = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    exp_pc_q  = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
    budget = 3;
    bus.fetch_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    drain("t1");

    // 2: decode stalls, buffer fills to two, then drains and fetch resumes.
    bus.fetch_ready = 1'b0;
    exp_req_q = '{32'h8000_000C, 32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_001C};
    exp_pc_q  = '{32'h8000_000C, 32'h8000_0010, 32'h8000_0014, 32'h8000_0018, 32'h8000_001C};
    budget = 5;
    repeat (10) @(negedge clk);
    #3;
    chk("t2_req_valid_full", {63'h0, bus.fetch_req_valid}, 64'h0);
    chk("t2_out_valid", {63'h0, bus.fetch_valid}, 64'h1);
    chk("t2_accepted", 64'(5 - budget), 64'h2);
    chk("t2_head_pc", {32'h0, bus.fetch_pc}, {32'h0, 32'h8000_000C});
    bus.fetch_ready = 1'b1;
    drain("t2");

    // 3: redirect while waiting for a slow response.
    lat = 3;
    exp_req_q = '{32'h8000_0020, 32'h8000_0100, 32'h8000_0104};
    exp_pc_q  = '{32'h8000_0100, 32'h8000_0104};
    base = hs_count;
    budget = 1;
    wait_hs("t3", base);
    @(negedge clk);
    bus.fetch_redir_en = 1'b1;
    bus.fetch_redir_pc = 32'h8000_0100;
    @(negedge clk);
    bus.fetch_redir_en = 1'b0;
    lat    = 1;
    budget = 2;
    drain("t3");

    // 4a: redirect in the same cycle as the response.
    exp_req_q = '{32'h8000_0108, 32'h8000_0100};
    exp_pc_q  = '{32'h8000_0100};
    base = hs_count;
    budget = 1;
    wait_hs("t4a", base);
    @(negedge clk);
    bus.fetch_redir_en = 1'b1;
    bus.fetch_redir_pc = 32'h8000_0100;
    @(negedge clk);
    bus.fetch_redir_en = 1'b0;
    budget = 1;
    drain("t4a");

    // 4b: redirect in the same cycle as the request handshake.
    exp_req_q = '{32'h8000_0104, 32'h8000_0100};
    exp_pc_q  = '{32'h8000_0100};
    @(negedge clk);
    budget = 1;
    bus.fetch_redir_en = 1'b1;
    bus.fetch_redir_pc = 32'h8000_0100;
    @(negedge clk);
    bus.fetch_redir_en = 1'b0;
    budget = 1;
    drain("t4b");

    // 5: PC wrap past the top of the address space, then a misaligned target.
    @(negedge clk);
    bus.fetch_redir_en = 1'b1;
    bus.fetch_redir_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    bus.fetch_redir_en = 1'b0;
    exp_req_q = '{32'hFFFF_FFFC, 32'h0000_0000};
    exp_pc_q  = '{32'hFFFF_FFFC, 32'h0000_0000};
    budget = 2;
    drain("t5_wrap");
    @(negedge clk);
    bus.fetch_redir_en = 1'b1;
    bus.fetch_redir_pc = 32'h8000_0102;
    @(negedge clk);
    bus.fetch_redir_en = 1'b0;
    exp_req_q = '{32'h8000_0100};
    exp_pc_q  = '{32'h8000_0100};
    budget = 1;
    drain("t5_align");

    // 6: asynchronous reset with a buffered word and a request in flight.
    bus.fetch_ready = 1'b0;
    exp_req_q = '{32'h8000_0104};
    exp_pc_q  = '{32'h8000_0104};
    budget = 1;
    repeat (4) @(negedge clk);
    #3;
    chk("t6_buffered", {63'h0, bus.fetch_valid}, 64'h1);
    lat = 10;
    exp_req_q = '{32'h8000_0108};
    base = hs_count;
    budget = 1;
    wait_hs("t6", base);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_req_valid", {63'h0, bus.fetch_req_valid}, 64'h0);
    chk("t6_rst_valid", {63'h0, bus.fetch_valid}, 64'h0);
    chk("t6_rst_pc_inst", {bus.fetch_pc, bus.fetch_inst}, 64'h0);
    chk("t6_rst_opcode", {57'h0, bus.fetch_opcode}, 64'h0);
    exp_pc_q.delete();
    exp_req_q.delete();
    repeat (2) @(negedge clk);
    lat    = 1;
    budget = 1;
    exp_req_q = '{32'h8000_0000};
    exp_pc_q  = '{32'h8000_0000};
    bus.fetch_ready = 1'b1;
    rst_n = 1'b1;
    drain("t6_restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
